// File: rtl/subtrai_serial.sv
// subtrai_serial
// Bit-serial unsigned subtractor. It computes a - b one bit per clock, starting
// from the LSB. A single full-subtractor cell and a registered borrow do the work.
// A start/busy/done handshake wraps the operation.
//
// Ports:
//   clk    - clock; all state changes on the rising edge
//   rst    - synchronous, active-high reset; takes priority over start
//   start  - request; sampled only in IDLE or DONE
//   a, b   - minuend / subtrahend, captured on the edge that accepts start
//   busy   - high while the subtraction is running (WIDTH cycles)
//   done   - one-cycle pulse; diff/b_out/zero are valid from this cycle
//   diff   - (a - b) mod 2^WIDTH, held until the next completion
//   b_out  - final borrow, 1 iff a < b (unsigned)
//   zero   - 1 iff diff == 0
module subtrai_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sd;
  logic             r_br;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_br_nxt;
  logic [WIDTH-1:0] w_sd_nxt;

  // Full-subtractor cell on the current LSBs.
  // It borrows when a=0,b=1, or when the bits are equal and a borrow is pending.
  assign w_d      = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_br_nxt = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
  assign w_sd_nxt = {w_d, r_sd[WIDTH-1:1]};

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sd    <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      diff    <= '0;
      b_out   <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sd  <= w_sd_nxt;
          r_br  <= w_br_nxt;
          r_cnt <= r_cnt + CW'(1);
          // The last bit publishes the result. The outputs stay frozen during RUN
          // so a consumer never sees a partially shifted value.
          if (r_cnt == LAST) begin
            diff    <= w_sd_nxt;
            b_out   <= w_br_nxt;
            zero    <= (w_sd_nxt == '0);
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/subtrai_serial.md
# subtrai_serial

Bit-serial subtractor: computes `a - b` one bit per clock using a single full-subtractor cell and a registered borrow, with a start/busy/done handshake. It is the inverse-operation companion to the combinational ripple adders (`soma1ports` / `soma4bit`). It serves datapaths that can trade latency for area, and gives the ALU a subtraction path with borrow and zero flags.

## Interface
- `WIDTH`, default 4: operand and result width in bits. Legal values are 2 to 32.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request. Sampled only in IDLE or DONE.
- `a` in WIDTH: minuend. Captured on the edge that accepts `start`.
- `b` in WIDTH: subtrahend. Captured on the same edge.
- `busy` out 1: high while a subtraction is in progress.
- `done` out 1: one-cycle pulse; result outputs became valid on that edge.
- `diff` out WIDTH: `(a - b) mod 2^WIDTH`.
- `b_out` out 1: final borrow. It is 1 iff `a < b` (unsigned).
- `zero` out 1: 1 iff `diff == 0`.

## Operation
- States are IDLE, RUN and DONE. Encoding is free; the state register is reset to IDLE.
- Internal registers:
  - `sa`, `sb`: WIDTH-bit operand shift registers.
  - `sd`: WIDTH-bit result shift register.
  - `br`: 1-bit borrow.
  - `cnt`: counter sized for values 0 to WIDTH-1.
- IDLE or DONE with `start=1`:
  - `sa<=a`, `sb<=b`, `br<=0`, `cnt<=0`, next state RUN.
- IDLE or DONE with `start=0`:
  - From DONE, go to IDLE. From IDLE, stay.
- RUN, each edge:
  - Bit operation: `d = sa[0]^sb[0]^br`; `br <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br)`.
  - Shifts: `sa`, `sb` shift right by 1; `sd <= {d, sd[WIDTH-1:1]}`.
  - Counter: `cnt <= cnt+1`.
- RUN, the edge with `cnt==WIDTH-1` (last bit):
  - Registered outputs load: `diff <= {d, sd[WIDTH-1:1]}`, `b_out <=` the new borrow, `zero <=` (that new diff == 0).
  - Next state DONE.
- `start` while in RUN is ignored. Operands are not re-captured and the operation is unaffected.
- `diff`, `b_out` and `zero` hold their last result until the next completion. They do not change during RUN.
- `busy` = (state==RUN). `done` = (state==DONE). Both are derived from the state register, so they are glitch-free registered decodes.
- All arithmetic is unsigned modulo 2^WIDTH. There is no overflow flag. Signed interpretation is left to the consumer: `diff` is the correct two's-complement difference, and `b_out` is not a signed overflow.

## Timing
- Reset (`rst=1` on an edge, any state):
  - state becomes IDLE.
  - `busy`, `done`, `diff`, `b_out`, `zero`, `sa`, `sb`, `sd`, `br`, `cnt` all become 0.
  - `rst` has priority over `start`.
- Reset during RUN aborts the operation: no `done` pulse, and `diff` is cleared to 0.
- Latency: `start` is sampled at edge E0.
  - `busy` is high after E0 through E(WIDTH-1), i.e. WIDTH cycles.
  - `done` is high for exactly one cycle after E(WIDTH); the result is valid from that same point.
- Back-to-back: `start=1` during the DONE cycle is accepted.
  - Sustained throughput is one result per WIDTH+1 cycles.
  - `done` deasserts and `busy` asserts on that same edge.
- `a` and `b` may change freely after the accepting edge.

## Test plan
- Basic subtraction, WIDTH=4: `a=4, b=2`, pulse `start` -> after 4 cycles: `done=1` for 1 cycle, `diff=2`, `b_out=0`, `zero=0`; `busy` high for exactly 4 cycles.
- Borrow and wrap: `a=2, b=4` -> `diff=14` (4'b1110), `b_out=1`, `zero=0`. Then `a=0, b=15` -> `diff=1`, `b_out=1`.
- Zero flag: `a=9, b=9` -> `diff=0`, `zero=1`, `b_out=0`. Then `a=15, b=0` -> `diff=15`, `zero=0`, `b_out=0`.
- Handshake robustness:
  - Hold `start=1` continuously with `a=10, b=6` -> results of `4` arrive every 5 cycles.
  - Change `a`/`b` and pulse `start` mid-RUN -> the current result is still `4`, and no extra `done` pulse occurs.
- Reset mid-operation: start `a=7, b=3`, assert `rst` after 2 cycles -> next cycle all outputs 0, no `done`. A new `start` with `a=7, b=3` then yields `diff=4` after 4 cycles.
- Exhaustive sweep, WIDTH=4: all 256 `(a,b)` pairs back-to-back -> `diff==(a-b)&15`, `b_out==(a<b)`, `zero==(a==b)` on every `done`.
